// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit pipelined processor.
//
// Contents:
//   opcode_e        - instruction opcodes (instr[15:12])
//   ALUOP_*         - ALU operation class encodings carried to EX
//   ctrl_t          - ID/EX control bundle
//   CTRL_NOP        - all-zero bundle used for bubbles, flushes and reset
//   decode_ctrl()   - opcode -> control bundle
//   is_valid_op()   - 1 for opcodes that decode to a real instruction
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_LW    = 4'b0001,
        OP_SW    = 4'b0010,
        OP_BEQ   = 4'b0011,
        OP_ADDI  = 4'b0100
    } opcode_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.memto_reg = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.branch    = 1'b1;
                c.alu_op    = ALUOP_SUB;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALUOP_ADD;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        logic v;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: v = 1'b1;
            default:                                 v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile8x16.sv
// ----------------------------------------------------------------------------
// regfile8x16
// 8-entry architectural register file, two combinational read ports and one
// write port. r0 is hard-wired to zero; writes to it are dropped.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a write in progress is forwarded to a read of the same
//               (non-zero) register in the same cycle (write-before-read)
//   undefined - reads return the stored value until after the clock edge
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset (clears r1..r7)
//   i_we, i_wr_addr,
//   i_wr_data              write port, written on posedge i_clk
//   i_rd_addr1/2           read addresses (rs / rt)
//   o_rd_data1/2           read data
// ----------------------------------------------------------------------------
module regfile8x16 #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [2:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [2:0]        i_rd_addr1,
    input  logic [2:0]        i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2
);

    logic [DATA_W-1:0] w_regs [8];

    // Entry 0 is a constant; entries 1..7 are individually reset storage.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_data;
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_data <= '0;
                    end else if (i_we && (i_wr_addr == 3'(gi))) begin
                        r_data <= i_wr_data;
                    end
                end
                assign w_regs[gi] = r_data;
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;
    assign w_byp1 = i_we && (i_wr_addr != 3'd0) && (i_wr_addr == i_rd_addr1);
    assign w_byp2 = i_we && (i_wr_addr != 3'd0) && (i_wr_addr == i_rd_addr2);
    assign o_rd_data1 = w_byp1 ? i_wr_data : w_regs[i_rd_addr1];
    assign o_rd_data2 = w_byp2 ? i_wr_data : w_regs[i_rd_addr2];
`else
    assign o_rd_data1 = w_regs[i_rd_addr1];
    assign o_rd_data2 = w_regs[i_rd_addr2];
`endif

endmodule

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
// Instruction-decode stage: register file reads, control decode, immediate
// sign-extension, load-use hazard detection and a saturating stall counter.
// All outputs except o_stall_count are combinational and are captured by the
// ID/EX register at the next posedge.
//
// Optional feature macro: REGFILE_BYPASS_EN (passed through to regfile8x16).
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_instr, i_pc_in            instruction and incremented PC from IF/ID
//   i_flush                     squash the instruction in decode
//   i_wb_reg_write/rd/data      write-back port
//   i_id_ex_mem_read, i_id_ex_rt  load-in-EX information for hazard check
//   o_reg_write .. o_alu_op     control bundle to ID/EX
//   o_adder2_out                PC passthrough
//   o_rd_data1/2                rs / rt register values
//   o_se_out                    sign-extended 6-bit immediate
//   o_rd, o_rt                  destination register fields
//   o_pc_write, o_if_id_write   low = hold PC / hold IF/ID
//   o_stall_count               saturating count of stall cycles
// ----------------------------------------------------------------------------
module decode_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       i_instr,
    input  logic [PC_W-1:0]   i_pc_in,
    input  logic              i_flush,
    input  logic              i_wb_reg_write,
    input  logic [2:0]        i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_id_ex_mem_read,
    input  logic [2:0]        i_id_ex_rt,
    output logic              o_reg_write,
    output logic              o_memto_reg,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic              o_branch,
    output logic              o_alu_src,
    output logic              o_reg_dst,
    output logic [1:0]        o_alu_op,
    output logic [PC_W-1:0]   o_adder2_out,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic [DATA_W-1:0] o_se_out,
    output logic [2:0]        o_rd,
    output logic [2:0]        o_rt,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic [15:0]       o_stall_count
);

    logic [3:0] w_opcode;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic [5:0] w_imm;
    ctrl_t      w_ctrl_dec;
    ctrl_t      w_ctrl_out;
    logic       w_stall;
    logic       w_bubble;
    logic [15:0] r_stall_count;

    assign w_opcode = i_instr[15:12];
    assign w_rs     = i_instr[11:9];
    assign w_rt     = i_instr[8:6];
    assign w_imm    = i_instr[5:0];

    regfile8x16 #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_we       (i_wb_reg_write),
        .i_wr_addr  (i_wb_rd),
        .i_wr_data  (i_wb_data),
        .i_rd_addr1 (w_rs),
        .i_rd_addr2 (w_rt),
        .o_rd_data1 (o_rd_data1),
        .o_rd_data2 (o_rd_data2)
    );

    assign w_ctrl_dec = decode_ctrl(w_opcode);

    // Load-use hazard. Qualifying with i_rst_n makes an asserted reset release
    // a stall immediately rather than at the next edge.
    assign w_stall = i_rst_n && i_id_ex_mem_read &&
                     ((i_id_ex_rt == w_rs) || (i_id_ex_rt == w_rt)) &&
                     is_valid_op(w_opcode) && !i_flush;

    // Flush and reset also zero the bundle; flush already masks the stall.
    assign w_bubble   = w_stall || i_flush || !i_rst_n;
    assign w_ctrl_out = w_bubble ? CTRL_NOP : w_ctrl_dec;

    assign o_reg_write = w_ctrl_out.reg_write;
    assign o_memto_reg = w_ctrl_out.memto_reg;
    assign o_mem_write = w_ctrl_out.mem_write;
    assign o_mem_read  = w_ctrl_out.mem_read;
    assign o_branch    = w_ctrl_out.branch;
    assign o_alu_src   = w_ctrl_out.alu_src;
    assign o_reg_dst   = w_ctrl_out.reg_dst;
    assign o_alu_op    = w_ctrl_out.alu_op;

    assign o_pc_write    = !w_stall;
    assign o_if_id_write = !w_stall;

    assign o_adder2_out = i_pc_in;
    assign o_se_out     = {{(DATA_W-6){w_imm[5]}}, w_imm};
    assign o_rd         = i_instr[5:3];
    assign o_rt         = w_rt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage. Each scenario task drives a table of
// stimulus, pushes the model's expectation into a scoreboard queue and pops
// it when the outputs are sampled (4 ns after the driving edge).
// ----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int DATA_W = 16;
    localparam int PC_W   = 8;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [15:0]       instr;
    logic [PC_W-1:0]   pc_in;
    logic              flush;
    logic              wb_we;
    logic [2:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              ie_mr;
    logic [2:0]        ie_rt;
    logic              reg_write, memto_reg, mem_write, mem_read, branch, alu_src, reg_dst;
    logic [1:0]        alu_op;
    logic [PC_W-1:0]   adder2_out;
    logic [DATA_W-1:0] rd_data1, rd_data2, se_out;
    logic [2:0]        rd_f, rt_f;
    logic              pc_write, if_id_write;
    logic [15:0]       stall_count;

    decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_instr          (instr),
        .i_pc_in          (pc_in),
        .i_flush          (flush),
        .i_wb_reg_write   (wb_we),
        .i_wb_rd          (wb_rd),
        .i_wb_data        (wb_data),
        .i_id_ex_mem_read (ie_mr),
        .i_id_ex_rt       (ie_rt),
        .o_reg_write      (reg_write),
        .o_memto_reg      (memto_reg),
        .o_mem_write      (mem_write),
        .o_mem_read       (mem_read),
        .o_branch         (branch),
        .o_alu_src        (alu_src),
        .o_reg_dst        (reg_dst),
        .o_alu_op         (alu_op),
        .o_adder2_out     (adder2_out),
        .o_rd_data1       (rd_data1),
        .o_rd_data2       (rd_data2),
        .o_se_out         (se_out),
        .o_rd             (rd_f),
        .o_rt             (rt_f),
        .o_pc_write       (pc_write),
        .o_if_id_write    (if_id_write),
        .o_stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ins;
        logic [7:0]  pc;
        logic        we;
        logic [2:0]  wrd;
        logic [15:0] wdat;
        logic        mr;
        logic [2:0]  irt;
        logic        fl;
    } stim_t;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic        pcw;
        logic        ifw;
        logic [15:0] cnt;
        logic        chk_data;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] se;
        logic [7:0]  pc;
        logic [2:0]  rd;
        logic [2:0]  rt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_cnt  = 0;
    logic [15:0] model_rf [8];

    // Control bundle order: regWrite memtoReg memWrite memRead branch aluSrc regDst aluOp[1:0]
    function automatic logic [8:0] model_ctrl(input logic [3:0] op);
        case (op)
            4'h0:    return 9'b1_0_0_0_0_0_1_10;
            4'h1:    return 9'b1_1_0_1_0_1_0_00;
            4'h2:    return 9'b0_0_1_0_0_1_0_00;
            4'h3:    return 9'b0_0_0_0_1_0_0_01;
            4'h4:    return 9'b1_0_0_0_0_1_0_00;
            default: return 9'b0;
        endcase
    endfunction

    function automatic logic model_stall();
        return rst_n && ie_mr && (ie_rt == instr[11:9] || ie_rt == instr[8:6]) &&
               (instr[15:12] <= 4'h4) && !flush;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
        if (BYPASS && wb_we && wb_rd == a) return wb_data;
        return model_rf[a];
    endfunction

    function automatic exp_t build_exp();
        exp_t e;
        logic st;
        st         = model_stall();
        e.ctrl     = (st || flush || !rst_n) ? 9'b0 : model_ctrl(instr[15:12]);
        e.pcw      = !st;
        e.ifw      = !st;
        e.cnt      = exp_cnt[15:0];
        e.chk_data = !st;
        e.rd1      = model_read(instr[11:9]);
        e.rd2      = model_read(instr[8:6]);
        e.se       = {{10{instr[5]}}, instr[5:0]};
        e.pc       = pc_in;
        e.rd       = instr[5:3];
        e.rt       = instr[8:6];
        return e;
    endfunction

    function automatic logic [8:0] obs_ctrl();
        return {reg_write, memto_reg, mem_write, mem_read, branch, alu_src, reg_dst, alu_op};
    endfunction

    // Retire the current cycle into the model, cross the edge, then drive.
    task automatic apply(input stim_t s);
        if (rst_n) begin
            if (model_stall() && exp_cnt < 65535) exp_cnt++;
            if (wb_we && wb_rd != 3'd0) model_rf[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
        instr   = s.ins;
        pc_in   = s.pc;
        wb_we   = s.we;
        wb_rd   = s.wrd;
        wb_data = s.wdat;
        ie_mr   = s.mr;
        ie_rt   = s.irt;
        flush   = s.fl;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1;
        instr = 16'h4441; pc_in = 8'h00; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 3'd0; wb_data = 16'h0;
        ie_mr = 1'b1; ie_rt = 3'd2;
        for (int i = 0; i < 8; i++) model_rf[i] = 16'h0;
        #1 rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            sb.push_back(build_exp());
            e = sb.pop_front();
            n_checks++;
            if ({obs_ctrl(), pc_write, if_id_write} !== {e.ctrl, e.pcw, e.ifw})
                $display("FAIL reset_ctrl[%0d]: got ctrl=%b pcw=%b ifw=%b, want ctrl=%b pcw=%b ifw=%b",
                         k, obs_ctrl(), pc_write, if_id_write, e.ctrl, e.pcw, e.ifw);
            else n_pass++;
            n_checks++;
            if (stall_count !== e.cnt)
                $display("FAIL reset_count[%0d]: got %h want %h", k, stall_count, e.cnt);
            else n_pass++;
            $display("reset[%0d]: ctrl=%b pcw=%b cnt=%h", k, obs_ctrl(), pc_write, stall_count);
            @(posedge clk);
        end
        #2 ie_mr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        stim_t tbl [9];
        exp_t  e;
        tbl = '{
            '{16'hF000, 8'h01, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0},
            '{16'h06C0, 8'h02, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h12BE, 8'h03, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h2AC5, 8'h04, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h3283, 8'h05, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h4445, 8'h06, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h46E0, 8'hFF, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'hF123, 8'h80, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h7FFF, 8'h81, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i]);
            sb.push_back(build_exp());
            #3;
            e = sb.pop_front();
            n_checks++;
            if ({obs_ctrl(), pc_write, if_id_write} !== {e.ctrl, e.pcw, e.ifw})
                $display("FAIL decode_ctrl[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, obs_ctrl(), pc_write, if_id_write, e.ctrl, e.pcw, e.ifw);
            else n_pass++;
            n_checks++;
            if ({rd_data1, rd_data2, se_out, adder2_out, rd_f, rt_f} !== {e.rd1, e.rd2, e.se, e.pc, e.rd, e.rt})
                $display("FAIL decode_data[%0d]: got rd1=%h rd2=%h se=%h pc=%h rd=%0d rt=%0d want rd1=%h rd2=%h se=%h pc=%h rd=%0d rt=%0d",
                         i, rd_data1, rd_data2, se_out, adder2_out, rd_f, rt_f, e.rd1, e.rd2, e.se, e.pc, e.rd, e.rt);
            else n_pass++;
            $display("decode instr=%h ctrl=%b rd1=%h rd2=%h se=%h", tbl[i].ins, obs_ctrl(), rd_data1, rd_data2, se_out);
        end
    endtask

    task automatic test_stall();
        stim_t tbl [7];
        exp_t  e;
        tbl = '{
            '{16'h4441, 8'h10, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0},
            '{16'h4441, 8'h10, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0},
            '{16'h4441, 8'h10, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0},
            '{16'h0080, 8'h11, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0},
            '{16'hF480, 8'h12, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0},
            '{16'h4441, 8'h13, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0},
            '{16'h4441, 8'h14, 1'b0, 3'd0, 16'h0, 1'b0, 3'd2, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i]);
            sb.push_back(build_exp());
            #3;
            e = sb.pop_front();
            n_checks++;
            if ({obs_ctrl(), pc_write, if_id_write} !== {e.ctrl, e.pcw, e.ifw})
                $display("FAIL stall_ctrl[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, obs_ctrl(), pc_write, if_id_write, e.ctrl, e.pcw, e.ifw);
            else n_pass++;
            n_checks++;
            if (stall_count !== e.cnt)
                $display("FAIL stall_count[%0d]: got %h want %h", i, stall_count, e.cnt);
            else n_pass++;
            $display("stall instr=%h mr=%b irt=%0d pcw=%b cnt=%h", tbl[i].ins, tbl[i].mr, tbl[i].irt, pc_write, stall_count);
        end
    endtask

    task automatic test_flush();
        stim_t tbl [4];
        exp_t  e;
        tbl = '{
            '{16'h4441, 8'h20, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b1},
            '{16'h4441, 8'h21, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b1},
            '{16'h06C0, 8'h22, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1},
            '{16'h06C0, 8'h23, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0}
        };
        for (int i = 0; i < 4; i++) begin
            apply(tbl[i]);
            sb.push_back(build_exp());
            #3;
            e = sb.pop_front();
            n_checks++;
            if ({obs_ctrl(), pc_write, if_id_write} !== {e.ctrl, e.pcw, e.ifw})
                $display("FAIL flush_ctrl[%0d]: got %b/%b/%b want %b/%b/%b",
                         i, obs_ctrl(), pc_write, if_id_write, e.ctrl, e.pcw, e.ifw);
            else n_pass++;
            n_checks++;
            if (stall_count !== e.cnt)
                $display("FAIL flush_count[%0d]: got %h want %h", i, stall_count, e.cnt);
            else n_pass++;
            $display("flush fl=%b ctrl=%b pcw=%b cnt=%h", tbl[i].fl, obs_ctrl(), pc_write, stall_count);
        end
    endtask

    task automatic test_bypass();
        stim_t tbl [6];
        exp_t  e;
        tbl = '{
            '{16'h0A00, 8'h30, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 1'b0},
            '{16'h0A00, 8'h31, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h0140, 8'h32, 1'b1, 3'd5, 16'hCAFE, 1'b0, 3'd0, 1'b0},
            '{16'h0140, 8'h33, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0},
            '{16'h0000, 8'h34, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0},
            '{16'h0000, 8'h35, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0}
        };
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i]);
            sb.push_back(build_exp());
            #3;
            e = sb.pop_front();
            n_checks++;
            if ({rd_data1, rd_data2} !== {e.rd1, e.rd2})
                $display("FAIL bypass_read[%0d]: got rd1=%h rd2=%h want rd1=%h rd2=%h",
                         i, rd_data1, rd_data2, e.rd1, e.rd2);
            else n_pass++;
            $display("bypass we=%b wrd=%0d instr=%h rd1=%h rd2=%h", tbl[i].we, tbl[i].wrd, tbl[i].ins, rd_data1, rd_data2);
        end
    endtask

    task automatic test_saturate();
        stim_t s;
        exp_t  e;
        int    guard;
        s = '{16'h44C1, 8'h40, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0};
        guard = 0;
        while (exp_cnt < 65535 && guard < 70000) begin
            apply(s);
            guard++;
        end
        n_checks++;
        if (exp_cnt < 65535) $display("FAIL saturate_budget: reached %0d want 65535", exp_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            apply(s);
            sb.push_back(build_exp());
            #3;
            e = sb.pop_front();
            n_checks++;
            if ({stall_count, pc_write} !== {e.cnt, e.pcw})
                $display("FAIL saturate_hold[%0d]: got cnt=%h pcw=%b want cnt=%h pcw=%b",
                         i, stall_count, pc_write, e.cnt, e.pcw);
            else n_pass++;
            $display("saturate cnt=%h pcw=%b", stall_count, pc_write);
        end
        // Reset asserted in the middle of a stall cycle.
        rst_n = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) model_rf[i] = 16'h0;
        #1;
        sb.push_back(build_exp());
        e = sb.pop_front();
        n_checks++;
        if ({obs_ctrl(), pc_write, if_id_write, stall_count} !== {e.ctrl, e.pcw, e.ifw, e.cnt})
            $display("FAIL midstall_reset: got ctrl=%b pcw=%b ifw=%b cnt=%h want ctrl=%b pcw=%b ifw=%b cnt=%h",
                     obs_ctrl(), pc_write, if_id_write, stall_count, e.ctrl, e.pcw, e.ifw, e.cnt);
        else n_pass++;
        n_checks++;
        if (rd_data2 !== e.rd2)
            $display("FAIL midstall_regclear: got r3=%h want %h", rd_data2, e.rd2);
        else n_pass++;
        $display("midstall reset cnt=%h pcw=%b r3=%h", stall_count, pc_write, rd_data2);
        ie_mr = 1'b0;
        #10 rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_stall();
        test_flush();
        test_bypass();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
